mem_port_arbiter: RTL and testbench

//  Shares the core's single RAM port (ram_en/addr/wdata/write_en/select) between the instruction-fetch requester and the
//  MEM-stage data requester. One transaction is in flight at a time. Data has priority, bounded by an anti-starvation streak

---
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the instruction-fetch and data requesters.
// One transaction in flight; data wins contention, bounded by a streak counter
// so that a waiting fetch is eventually served. Flushed fetches still complete
// on the RAM side but their response is swallowed.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch requester
  input  logic                inst_req_valid,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  output logic                inst_req_ready,
  input  logic                inst_flush,
  output logic                inst_resp_valid,
  output logic [DATA_W-1:0]   inst_resp_data,
  // data requester
  input  logic                data_req_valid,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic                data_req_we,
  input  logic [DATA_W-1:0]   data_req_wdata,
  input  logic [DATA_W/8-1:0] data_req_sel,
  output logic                data_req_ready,
  output logic                data_resp_valid,
  output logic [DATA_W-1:0]   data_resp_data,
  // RAM port
  output logic                ram_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_write_en,
  output logic [DATA_W-1:0]   ram_write_data,
  output logic [DATA_W/8-1:0] ram_select,
  input  logic                ram_ready,
  input  logic                ram_resp_valid,
  input  logic [DATA_W-1:0]   ram_read_data
);

  localparam int unsigned SEL_W    = DATA_W / 8;
  localparam int unsigned STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic                owner_inst_q, owner_inst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                drop_q, drop_d;
  logic                inst_resp_valid_q, inst_resp_valid_d;
  logic [DATA_W-1:0]   inst_resp_data_q, inst_resp_data_d;
  logic                data_resp_valid_q, data_resp_valid_d;
  logic [DATA_W-1:0]   data_resp_data_q, data_resp_data_d;

  logic grant_inst, grant_data, complete;

  // Arbitration: data wins unless it has hit its streak limit against a waiting fetch.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == StIdle) begin
      grant_inst = inst_req_valid && (!data_req_valid || (streak_q == STREAK_MAX));
      grant_data = data_req_valid && !grant_inst;
    end
  end

  // Transaction completes when the RAM responds after (or together with) acceptance.
  always_comb begin
    complete = ((state_q == StIssue) && ram_ready && ram_resp_valid) ||
               ((state_q == StWait) && ram_resp_valid);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_inst || grant_data) state_d = StIssue;
      end
      StIssue: begin
        if (ram_ready) state_d = ram_resp_valid ? StIdle : StWait;
      end
      StWait: begin
        if (ram_resp_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: readies only in idle, RAM request driven from latched fields in issue.
  always_comb begin
    inst_req_ready  = grant_inst;
    data_req_ready  = grant_data;
    ram_en          = (state_q == StIssue);
    ram_addr        = addr_q;
    ram_write_en    = we_q;
    ram_write_data  = wdata_q;
    ram_select      = sel_q;
    inst_resp_valid = inst_resp_valid_q;
    inst_resp_data  = inst_resp_data_q;
    data_resp_valid = data_resp_valid_q;
    data_resp_data  = data_resp_data_q;
  end

  // Next-state for request latch, streak counter, flush drop flag and responses.
  always_comb begin
    owner_inst_d      = owner_inst_q;
    addr_d            = addr_q;
    we_d              = we_q;
    wdata_d           = wdata_q;
    sel_d             = sel_q;
    streak_d          = streak_q;
    drop_d            = drop_q;
    inst_resp_valid_d = 1'b0;
    inst_resp_data_d  = inst_resp_data_q;
    data_resp_valid_d = 1'b0;
    data_resp_data_d  = data_resp_data_q;

    if (grant_inst) begin
      owner_inst_d = 1'b1;
      addr_d       = inst_req_addr;
      we_d         = 1'b0;
      wdata_d      = '0;
      sel_d        = '1;
      streak_d     = '0;
      drop_d       = inst_flush;
    end else if (grant_data) begin
      owner_inst_d = 1'b0;
      addr_d       = data_req_addr;
      we_d         = data_req_we;
      wdata_d      = data_req_wdata;
      sel_d        = data_req_sel;
      drop_d       = 1'b0;
      if (!inst_req_valid) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end

    // A flush at any point while a fetch is outstanding kills its response.
    if ((state_q != StIdle) && owner_inst_q && inst_flush) begin
      drop_d = 1'b1;
    end

    if (complete) begin
      drop_d = 1'b0;
      if (owner_inst_q) begin
        if (!drop_q && !inst_flush) begin
          inst_resp_valid_d = 1'b1;
          inst_resp_data_d  = ram_read_data;
        end
      end else begin
        data_resp_valid_d = 1'b1;
        data_resp_data_d  = we_q ? '0 : ram_read_data;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_inst_q      <= 1'b0;
      addr_q            <= '0;
      we_q              <= 1'b0;
      wdata_q           <= '0;
      sel_q             <= '0;
      streak_q          <= '0;
      drop_q            <= 1'b0;
      inst_resp_valid_q <= 1'b0;
      inst_resp_data_q  <= '0;
      data_resp_valid_q <= 1'b0;
      data_resp_data_q  <= '0;
    end else begin
      owner_inst_q      <= owner_inst_d;
      addr_q            <= addr_d;
      we_q              <= we_d;
      wdata_q           <= wdata_d;
      sel_q             <= sel_d;
      streak_q          <= streak_d;
      drop_q            <= drop_d;
      inst_resp_valid_q <= inst_resp_valid_d;
      inst_resp_data_q  <= inst_resp_data_d;
      data_resp_valid_q <= data_resp_valid_d;
      data_resp_data_q  <= data_resp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays both requesters and the RAM.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              inst_req_valid;
  logic [ADDR_W-1:0] inst_req_addr;
  logic              inst_req_ready;
  logic              inst_flush;
  logic              inst_resp_valid;
  logic [DATA_W-1:0] inst_resp_data;
  logic              data_req_valid;
  logic [ADDR_W-1:0] data_req_addr;
  logic              data_req_we;
  logic [DATA_W-1:0] data_req_wdata;
  logic [3:0]        data_req_sel;
  logic              data_req_ready;
  logic              data_resp_valid;
  logic [DATA_W-1:0] data_resp_data;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write_en;
  logic [DATA_W-1:0] ram_write_data;
  logic [3:0]        ram_select;
  logic              ram_ready;
  logic              ram_resp_valid;
  logic [DATA_W-1:0] ram_read_data;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_DATA_STREAK(4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req_valid (inst_req_valid),
    .inst_req_addr  (inst_req_addr),
    .inst_req_ready (inst_req_ready),
    .inst_flush     (inst_flush),
    .inst_resp_valid(inst_resp_valid),
    .inst_resp_data (inst_resp_data),
    .data_req_valid (data_req_valid),
    .data_req_addr  (data_req_addr),
    .data_req_we    (data_req_we),
    .data_req_wdata (data_req_wdata),
    .data_req_sel   (data_req_sel),
    .data_req_ready (data_req_ready),
    .data_resp_valid(data_resp_valid),
    .data_resp_data (data_resp_data),
    .ram_en         (ram_en),
    .ram_addr       (ram_addr),
    .ram_write_en   (ram_write_en),
    .ram_write_data (ram_write_data),
    .ram_select     (ram_select),
    .ram_ready      (ram_ready),
    .ram_resp_valid (ram_resp_valid),
    .ram_read_data  (ram_read_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  logic [2:0] grant_is_inst;
  logic [5:0] exp_order;

  initial begin
    rst            = 1'b0;
    inst_req_valid = 1'b0;
    inst_req_addr  = '0;
    inst_flush     = 1'b0;
    data_req_valid = 1'b0;
    data_req_addr  = '0;
    data_req_we    = 1'b0;
    data_req_wdata = '0;
    data_req_sel   = '0;
    ram_ready      = 1'b0;
    ram_resp_valid = 1'b0;
    ram_read_data  = '0;
    #2;
    check("rst_ram_en", {63'd0, ram_en}, 64'd0);
    check("rst_ram_select", {60'd0, ram_select}, 64'd0);
    check("rst_inst_resp", {63'd0, inst_resp_valid}, 64'd0);
    check("rst_data_resp", {63'd0, data_resp_valid}, 64'd0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // 1: lone fetch, RAM accepts at T+1 and responds at T+3
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0000;
    settle();
    check("t1_inst_ready", {63'd0, inst_req_ready}, 64'd1);
    check("t1_ram_en_T", {63'd0, ram_en}, 64'd0);
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    settle();
    check("t1_ram_en_T1", {63'd0, ram_en}, 64'd1);
    check("t1_ram_addr", {32'd0, ram_addr}, 64'h1C00_0000);
    check("t1_ram_sel", {60'd0, ram_select}, 64'hF);
    check("t1_ram_we", {63'd0, ram_write_en}, 64'd0);
    cyc();
    ram_ready = 1'b0;
    settle();
    check("t1_ram_en_T2", {63'd0, ram_en}, 64'd0);
    cyc();
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'h0280_0C0C;
    settle();
    check("t1_resp_early", {63'd0, inst_resp_valid}, 64'd0);
    cyc();
    ram_resp_valid = 1'b0;
    settle();
    check("t1_resp_valid", {63'd0, inst_resp_valid}, 64'd1);
    check("t1_resp_data", {32'd0, inst_resp_data}, 64'h0280_0C0C);
    cyc();
    check("t1_resp_pulse", {63'd0, inst_resp_valid}, 64'd0);

    // 2: simultaneous requests, data first, fetch accepted as data responds
    data_req_valid = 1'b1;
    data_req_addr  = 32'h1C00_8000;
    data_req_we    = 1'b0;
    data_req_sel   = 4'hF;
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0004;
    settle();
    check("t2_data_ready", {63'd0, data_req_ready}, 64'd1);
    check("t2_inst_ready0", {63'd0, inst_req_ready}, 64'd0);
    cyc();
    data_req_valid = 1'b0;
    ram_ready      = 1'b1;
    settle();
    check("t2_ram_addr", {32'd0, ram_addr}, 64'h1C00_8000);
    check("t2_inst_ready1", {63'd0, inst_req_ready}, 64'd0);
    cyc();
    ram_ready = 1'b0;
    settle();
    check("t2_inst_ready2", {63'd0, inst_req_ready}, 64'd0);
    cyc();
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'h1122_3344;
    cyc();
    ram_resp_valid = 1'b0;
    settle();
    check("t2_data_resp", {63'd0, data_resp_valid}, 64'd1);
    check("t2_data_rdata", {32'd0, data_resp_data}, 64'h1122_3344);
    check("t2_inst_b2b", {63'd0, inst_req_ready}, 64'd1);
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'h0000_0055;
    settle();
    check("t2_fetch_addr", {32'd0, ram_addr}, 64'h1C00_0004);
    cyc();
    ram_ready      = 1'b0;
    ram_resp_valid = 1'b0;
    settle();
    check("t2_inst_resp", {63'd0, inst_resp_valid}, 64'd1);
    check("t2_inst_rdata", {32'd0, inst_resp_data}, 64'h0000_0055);

    // 3: sustained contention, expect D,D,D,D,I,D (bit i = 1 means inst)
    exp_order      = 6'b01_0000;
    data_req_valid = 1'b1;
    data_req_addr  = 32'h1C00_8100;
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0008;
    for (int i = 0; i < 6; i++) begin
      settle();
      grant_is_inst = {1'b0, inst_req_ready, data_req_ready};
      check($sformatf("t3_grant%0d", i), {61'd0, grant_is_inst},
            exp_order[i] ? 64'd2 : 64'd1);
      check($sformatf("t3_no_overlap%0d", i), {63'd0, inst_resp_valid & data_resp_valid}, 64'd0);
      cyc();
      ram_ready      = 1'b1;
      ram_resp_valid = 1'b1;
      ram_read_data  = 32'h100 + i;
      if (i == 5) begin
        data_req_valid = 1'b0;
        inst_req_valid = 1'b0;
      end
      cyc();
      ram_ready      = 1'b0;
      ram_resp_valid = 1'b0;
    end
    settle();
    check("t3_last_data_resp", {63'd0, data_resp_valid}, 64'd1);

    // 4: flushed fetch returns nothing; the next fetch returns its own data
    cyc();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0008;
    settle();
    check("t4_inst_ready", {63'd0, inst_req_ready}, 64'd1);
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    cyc();
    ram_ready  = 1'b0;
    inst_flush = 1'b1;
    cyc();
    inst_flush     = 1'b0;
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'hDEAD_BEEF;
    cyc();
    ram_resp_valid = 1'b0;
    settle();
    check("t4_dropped", {63'd0, inst_resp_valid}, 64'd0);
    cyc();
    check("t4_dropped2", {63'd0, inst_resp_valid}, 64'd0);
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_000C;
    settle();
    check("t4_next_ready", {63'd0, inst_req_ready}, 64'd1);
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'h1234_5678;
    cyc();
    ram_ready      = 1'b0;
    ram_resp_valid = 1'b0;
    settle();
    check("t4_next_resp", {63'd0, inst_resp_valid}, 64'd1);
    check("t4_next_data", {32'd0, inst_resp_data}, 64'h1234_5678);

    // 5: store stalled by RAM for 5 cycles keeps request fields stable
    cyc();
    data_req_valid = 1'b1;
    data_req_addr  = 32'h1C00_FF00;
    data_req_we    = 1'b1;
    data_req_wdata = 32'hA5A5_A5A5;
    data_req_sel   = 4'b0011;
    settle();
    check("t5_data_ready", {63'd0, data_req_ready}, 64'd1);
    cyc();
    data_req_valid = 1'b0;
    data_req_wdata = '0;
    data_req_addr  = '0;
    for (int k = 0; k < 6; k++) begin
      ram_ready = (k == 5);
      settle();
      check($sformatf("t5_en%0d", k), {63'd0, ram_en}, 64'd1);
      check($sformatf("t5_addr%0d", k), {32'd0, ram_addr}, 64'h1C00_FF00);
      check($sformatf("t5_we%0d", k), {63'd0, ram_write_en}, 64'd1);
      check($sformatf("t5_wdata%0d", k), {32'd0, ram_write_data}, 64'hA5A5_A5A5);
      check($sformatf("t5_sel%0d", k), {60'd0, ram_select}, 64'h3);
      cyc();
    end
    ram_ready      = 1'b0;
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'hFFFF_FFFF;
    settle();
    check("t5_wait_en", {63'd0, ram_en}, 64'd0);
    cyc();
    ram_resp_valid = 1'b0;
    settle();
    check("t5_store_resp", {63'd0, data_resp_valid}, 64'd1);
    check("t5_store_data", {32'd0, data_resp_data}, 64'd0);
    data_req_we = 1'b0;

    // 6: reset asserted during WAIT clears outputs at once
    cyc();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0010;
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    cyc();
    ram_ready = 1'b0;
    settle();
    rst = 1'b0;
    settle();
    check("t6_rst_en", {63'd0, ram_en}, 64'd0);
    check("t6_rst_sel", {60'd0, ram_select}, 64'd0);
    check("t6_rst_addr", {32'd0, ram_addr}, 64'd0);
    check("t6_rst_idata", {32'd0, inst_resp_data}, 64'd0);
    check("t6_rst_iready", {63'd0, inst_req_ready}, 64'd0);
    cyc();
    rst = 1'b1;
    cyc();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h1C00_0014;
    settle();
    check("t6_post_ready", {63'd0, inst_req_ready}, 64'd1);
    cyc();
    inst_req_valid = 1'b0;
    ram_ready      = 1'b1;
    settle();
    check("t6_post_addr", {32'd0, ram_addr}, 64'h1C00_0014);
    cyc();
    ram_ready      = 1'b0;
    ram_resp_valid = 1'b1;
    ram_read_data  = 32'hCAFE_F00D;
    cyc();
    ram_resp_valid = 1'b0;
    settle();
    check("t6_post_resp", {63'd0, inst_resp_valid}, 64'd1);
    check("t6_post_data", {32'd0, inst_resp_data}, 64'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
